mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ROM_LIMIT, default 16'h0100: first RAM address; addresses below it decode to ROM.
REQ-002 Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_bar  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  16  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  16  CPU read data.
- dma_req, dma_we, dma_addr[16], dma_wdata[16]  in  DMA/loader equivalents of the cpu_* inputs.
- dma_ack  out  1  one-cycle completion pulse to DMA.
- dma_rdata  out  16  DMA read data.
- mem_address  out  16  Memory address.
- mem_en  out  1  Memory drives bus (read).
- mem_load_bar  out  1  Memory write strobe, active-low.
- mem_wdata  out  16  data driven onto bus.
- mem_oe  out  1  enables mem_wdata onto bus.
- mem_rdata  in  16  bus value during reads.
- busy  out  1  access in progress (state != IDLE).
- rom_fault  out  1  sticky ROM-write flag (REQ-016).

Function
REQ-003 FSM states IDLE, SETUP, ACCESS, ACK; IDLE->SETUP on any req; SETUP->ACCESS->ACK->IDLE unconditionally.
REQ-004 In IDLE, winner selection SHALL be combinational from cpu_req/dma_req; the winner's we/addr/wdata SHALL be registered on the IDLE->SETUP edge and held constant through ACK.
REQ-005 Arbitration: single requester wins; if both request, the requester NOT granted last wins (round-robin); after reset, last-granted = DMA, so CPU wins first tie.
REQ-006 Latency: req sampled high in IDLE at edge N -> matching ack high during cycle N+3 -> busy low at N+4; back-to-back throughput one access per 4 cycles.
REQ-007 SETUP: mem_address valid; mem_en=0, mem_load_bar=1; mem_oe=1 for writes.
REQ-008 ACCESS, read: mem_en=1, mem_oe=0; mem_rdata captured into winner's rdata register on the ACCESS->ACK edge.
REQ-009 ACCESS, write: mem_load_bar=0, mem_oe=1, mem_en=0; data held stable from SETUP through ACCESS.
REQ-010 mem_en and mem_oe SHALL never be 1 in the same cycle; mem_load_bar SHALL be 0 only in ACCESS.
REQ-011 ack pulses exactly one cycle in ACK, to the granted requester only; rdata registers hold value until next read for that requester.
REQ-012 Requesters hold req until ack; req still high in ACK cycle SHALL be re-arbitrated only in the following IDLE cycle (no skipped IDLE).
REQ-013 req dropped mid-access: access SHALL complete and ack still pulse.
REQ-014 Outside SETUP/ACCESS, mem_address = 0, mem_oe = 0.

Reset
REQ-015 reset_bar low SHALL immediately force: state IDLE, mem_en=0, mem_load_bar=1, mem_oe=0, mem_address=0, mem_wdata=0, acks=0, rdata=0, busy=0, rom_fault=0, last-granted=DMA; in-flight access is abandoned without ack.

Configuration
REQ-016 With ROM_WRITE_PROTECT_EN defined: write with addr < ROM_LIMIT SHALL keep mem_load_bar=1 and mem_oe=0, still ack normally, and set rom_fault (cleared only by reset).
REQ-017 Without ROM_WRITE_PROTECT_EN: such writes proceed per REQ-009; rom_fault tied 0.

Structure
REQ-018 Shared package mem_arb_pkg: FSM state encoding, grant encoding (GNT_CPU, GNT_DMA), ROM_LIMIT default.
REQ-019 Round-robin choice in sub-module rr_arbiter2 (2 reqs, last-granted register, grant out, update strobe).

Verification
REQ-020 CPU read 16'h1234, mem_rdata=16'hBEEF -> mem_en high one cycle, cpu_ack at N+3, cpu_rdata=16'hBEEF.
REQ-021 CPU write 16'h0300<-16'hA5A5 -> mem_load_bar low exactly one cycle, mem_oe high SETUP+ACCESS, mem_wdata=16'hA5A5.
REQ-022 cpu_req and dma_req held high 4 accesses after reset -> grants CPU, DMA, CPU, DMA; acks at cycles 3, 7, 11, 15.
REQ-023 DMA write to 16'h00FF: with macro -> no load_bar pulse, dma_ack, rom_fault=1; without -> pulse, rom_fault=0.
REQ-024 reset_bar low during ACCESS of write -> mem_load_bar=1 same cycle, no ack, next request served normally after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  // First RAM address; everything below decodes to ROM.
  localparam logic [ADDR_W-1:0] ROM_LIMIT_DEFAULT = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;

  // One requester's access payload.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; ties go to whoever was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_bar,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic update,
  output gnt_t gnt_c
);

  gnt_t last_gnt;

  // Combinational winner from the current requests and the last grant.
  always_comb begin
    gnt_c = GNT_CPU;
    if (cpu_req && dma_req) begin
      gnt_c = (last_gnt == GNT_DMA) ? GNT_CPU : GNT_DMA;
    end else if (dma_req) begin
      gnt_c = GNT_DMA;
    end
  end

  // Remember the winner whenever a grant is actually taken; DMA after reset so CPU wins the first tie.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      last_gnt <= GNT_DMA;
    end else if (update) begin
      last_gnt <= gnt_c;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA onto a single asynchronous memory bus with a fixed
// IDLE/SETUP/ACCESS/ACK sequence. Optional ROM write protection is enabled by
// defining ROM_WRITE_PROTECT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROM_LIMIT = ROM_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_en,
  output logic              mem_load_bar,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              rom_fault
);

`ifdef ROM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t state;
  gnt_t   gnt;
  logic   acc_we;
  logic   blocked;

  gnt_t   gnt_c;
  acc_t   win_c;
  logic   any_req_c;
  logic   update_c;
  logic   blk_c;

  // Grant is only taken in IDLE with at least one request pending.
  assign any_req_c = cpu_req || dma_req;
  assign update_c  = (state == ST_IDLE) && any_req_c;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset_bar (reset_bar),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .update    (update_c),
    .gnt_c     (gnt_c)
  );

  // Winner payload mux and ROM-write detection for the access about to start.
  always_comb begin
    win_c = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    if (gnt_c == GNT_DMA) begin
      win_c = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    end
    blk_c = WP_EN && win_c.we && (win_c.addr < ROM_LIMIT);
  end

  // Access sequencer; every bus and handshake output is registered here.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state        <= ST_IDLE;
      gnt          <= GNT_CPU;
      acc_we       <= 1'b0;
      blocked      <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_en       <= 1'b0;
      mem_load_bar <= 1'b1;
      mem_oe       <= 1'b0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      busy         <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            state       <= ST_SETUP;
            gnt         <= gnt_c;
            acc_we      <= win_c.we;
            blocked     <= blk_c;
            mem_address <= win_c.addr;
            mem_wdata   <= win_c.wdata;
            mem_oe      <= win_c.we && !blk_c;
            busy        <= 1'b1;
          end
        end
        ST_SETUP: begin
          state        <= ST_ACCESS;
          mem_en       <= !acc_we;
          mem_load_bar <= !(acc_we && !blocked);
        end
        ST_ACCESS: begin
          state        <= ST_ACK;
          mem_en       <= 1'b0;
          mem_load_bar <= 1'b1;
          mem_oe       <= 1'b0;
          mem_address  <= '0;
          if (gnt == GNT_CPU) begin
            cpu_ack <= 1'b1;
            if (!acc_we) cpu_rdata <= mem_rdata;
          end else begin
            dma_ack <= 1'b1;
            if (!acc_we) dma_rdata <= mem_rdata;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROM_WRITE_PROTECT_EN
  // Sticky flag raised by any suppressed ROM write; only reset clears it.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      rom_fault <= 1'b0;
    end else if ((state == ST_SETUP) && blocked) begin
      rom_fault <= 1'b1;
    end
  end
`else
  assign rom_fault = 1'b0;
`endif

endmodule
